// File: rtl/dm_pkg.sv
// dm_pkg: shared size codes, FSM states and byte-enable helper for the dm_bus data memory.
package dm_pkg;
   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;
   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
   function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] addr_lo);
      return size == SZ_BYTE ? 4'b0001 << addr_lo :
             size == SZ_HALF ? (addr_lo[1] ? 4'b1100 : 4'b0011) :
             size == SZ_WORD ? 4'b1111 : 4'b0000;
   endfunction
endpackage

// File: rtl/dm_lane_align.sv
// dm_lane_align: extracts the addressed byte/half lane of a little-endian word and sign/zero extends it.
module dm_lane_align
   import dm_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic        ld_unsigned,
   output logic [31:0] result
);
   logic [7:0]  b;
   logic [15:0] h;
   always_comb begin
      b = word[{addr_lo, 3'b000} +: 8];
      h = addr_lo[1] ? word[31:16] : word[15:0];
      result = size == SZ_BYTE ? {{24{b[7] & ~ld_unsigned}}, b} :
               size == SZ_HALF ? {{16{h[15] & ~ld_unsigned}}, h} :
               size == SZ_WORD ? word : '0;
   end
endmodule

// File: rtl/dm_bus.sv
// dm_bus: MIPS32 data memory with req/ready/rvalid handshake and WAIT_CYC wait states.
// Define DM_ALIGN_CHECK_EN to reject misaligned half/word accesses instead of aligning them down.
module dm_bus
   import dm_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int ADDR_W      = 12,
   parameter int WAIT_CYC    = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [1:0]        size,
   input  logic              ld_unsigned,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic              ready,
   output logic              rvalid,
   output logic [31:0]       rdata,
   output logic              err
);
   localparam int IW = $clog2(DEPTH_WORDS);
   state_t            state;
   logic [3:0]        cnt;
   logic              r_we;
   logic [1:0]        r_size;
   logic              r_uns;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic [31:0]       mem [DEPTH_WORDS];
   logic [IW-1:0]     idx;
   logic [1:0]        lo;
   logic              bad;
   logic [3:0]        be;
   logic [31:0]       wd;
   logic [31:0]       ld;
   logic              wr;
   always_comb begin
`ifdef DM_ALIGN_CHECK_EN
      bad = r_size == SZ_RSVD || (r_size == SZ_HALF && r_addr[0]) || (r_size == SZ_WORD && r_addr[1:0] != 2'b00);
      lo = r_addr[1:0];
`else
      bad = r_size == SZ_RSVD;
      lo = r_size == SZ_HALF ? {r_addr[1], 1'b0} : r_size == SZ_WORD ? 2'b00 : r_addr[1:0];
`endif
      idx = r_addr[2 +: IW];
      be = byte_en(r_size, lo);
      wd = r_size == SZ_BYTE ? {4{r_wdata[7:0]}} : r_size == SZ_HALF ? {2{r_wdata[15:0]}} : r_wdata;
      wr = state == ST_RESP && r_we && !bad && !rst;
   end
   dm_lane_align u_align (
      .word        (mem[idx]),
      .size        (r_size),
      .addr_lo     (lo),
      .ld_unsigned (r_uns),
      .result      (ld)
   );
   // Array is not reset, so it lives in its own clock-only block.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         if (wr && be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         r_we    <= 1'b0;
         r_size  <= '0;
         r_uns   <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         ready   <= 1'b1;
         rvalid  <= 1'b0;
         rdata   <= '0;
         err     <= 1'b0;
      end else begin
         rvalid <= 1'b0;
         case (state)
            ST_IDLE: if (req) begin
               r_we    <= we;
               r_size  <= size;
               r_uns   <= ld_unsigned;
               r_addr  <= addr;
               r_wdata <= wdata;
               cnt     <= 4'(WAIT_CYC - 1);
               ready   <= 1'b0;
               state   <= WAIT_CYC > 0 ? ST_WAIT : ST_RESP;
            end
            ST_WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd0) state <= ST_RESP;
            end
            default: begin
               rvalid <= 1'b1;
               err    <= bad;
               rdata  <= bad || r_we ? 32'd0 : ld;
               ready  <= 1'b1;
               state  <= ST_IDLE;
            end
         endcase
      end
   end
endmodule
